// File: rtl/sap_accumulator_reg_pkg.sv
// sap_accumulator_reg_pkg: datapath width and control-word bit positions shared across the SAP CPU
package sap_accumulator_reg_pkg;
  localparam int DATA_W = 8;
  localparam int CTRL_W = 16;
  localparam int LOAD_A = 5;
  localparam int EN_A = 4;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CTRL_W-1:0] ctrl_t;
endpackage

// File: rtl/sap_accumulator_reg_if.sv
// sap_accumulator_reg_if: bus, strobes and outputs of the accumulator register
interface sap_accumulator_reg_if import sap_accumulator_reg_pkg::*; #(parameter int WIDTH = DATA_W);
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] bus_out;
  logic load;
  logic enable_output;
  logic bus_oe;
  modport master(output bus, load, enable_output, input regA, bus_out, bus_oe);
  modport slave(input bus, load, enable_output, output regA, bus_out, bus_oe);
endinterface

// File: rtl/sap_accumulator_reg.sv
// sap_accumulator_reg: register A, loads from the bus and drives it back when output-enabled
module sap_accumulator_reg import sap_accumulator_reg_pkg::*; #(
  parameter int WIDTH = DATA_W
) (
  input logic clk,
  input logic rst,
  sap_accumulator_reg_if.slave acc
);
  logic [WIDTH-1:0] q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (acc.load) q <= acc.bus;
  assign acc.regA = q;
  assign acc.bus_out = acc.enable_output ? q : '0;
  assign acc.bus_oe = acc.enable_output;
endmodule

// File: tb/tb_sap_accumulator_reg.sv
// tb_sap_accumulator_reg: scoreboard-driven checks of load, hold, output enable and reset
module tb_sap_accumulator_reg;
  import sap_accumulator_reg_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  sap_accumulator_reg_if #(.WIDTH(DATA_W)) acc();
  sap_accumulator_reg #(.WIDTH(DATA_W)) dut(.clk(clk), .rst(rst), .acc(acc.slave));
  int total = 0;
  int bad = 0;
  data_t exp_q[$];
  data_t e;
  data_t model;
  task automatic load_value(input data_t v);
    @(negedge clk);
    acc.bus = v;
    acc.load = 1'b1;
    @(posedge clk);
    #1;
    acc.load = 1'b0;
    model = v;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    acc.bus = '0;
    acc.load = 1'b0;
    acc.enable_output = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    load_value(8'($urandom_range(1, 255)));
    @(negedge clk);
    acc.enable_output = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (acc.regA !== 8'h00) begin bad++; $display("FAIL reset_async regA got=%h want=00", acc.regA); end
    total++;
    if (acc.bus_out !== 8'h00) begin bad++; $display("FAIL reset_bus_out got=%h want=00", acc.bus_out); end
    total++;
    if (acc.bus_oe !== 1'b1) begin bad++; $display("FAIL reset_bus_oe got=%b want=1", acc.bus_oe); end
    @(negedge clk);
    acc.enable_output = 1'b0;
    rst = 1'b0;
    model = 8'h00;
  endtask
  task automatic test_load;
    @(negedge clk);
    acc.bus = 8'h5A;
    acc.load = 1'b1;
    exp_q.push_back(8'h5A);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    if (acc.regA !== e) begin bad++; $display("FAIL load regA got=%h want=%h", acc.regA, e); end
    @(negedge clk);
    acc.bus = 8'hFF;
    acc.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h5A);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if (acc.regA !== e) begin bad++; $display("FAIL hold%0d regA got=%h want=%h", i, acc.regA, e); end
    end
    model = 8'h5A;
  endtask
  task automatic test_output_enable;
    load_value(8'h3C);
    @(negedge clk);
    acc.enable_output = 1'b1;
    #1;
    total++;
    if (acc.bus_out !== 8'h3C || acc.bus_oe !== 1'b1) begin
      bad++; $display("FAIL oe_on bus_out=%h bus_oe=%b want=3c/1", acc.bus_out, acc.bus_oe);
    end
    acc.enable_output = 1'b0;
    #1;
    total++;
    if (acc.bus_out !== 8'h00 || acc.bus_oe !== 1'b0) begin
      bad++; $display("FAIL oe_off bus_out=%h bus_oe=%b want=00/0", acc.bus_out, acc.bus_oe);
    end
  endtask
  task automatic test_simultaneous;
    load_value(8'h11);
    @(negedge clk);
    acc.bus = 8'h22;
    acc.load = 1'b1;
    acc.enable_output = 1'b1;
    exp_q.push_back(8'h22);
    #1;
    total++;
    if (acc.bus_out !== 8'h11) begin bad++; $display("FAIL self_loop_pre bus_out got=%h want=11", acc.bus_out); end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    if (acc.regA !== e || acc.bus_out !== e) begin
      bad++; $display("FAIL self_loop_post regA=%h bus_out=%h want=%h", acc.regA, acc.bus_out, e);
    end
    acc.load = 1'b0;
    acc.enable_output = 1'b0;
    model = 8'h22;
  endtask
  task automatic test_boundaries;
    data_t vals[3];
    vals = '{8'h00, 8'hFF, 8'h80};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acc.bus = vals[i];
      acc.load = 1'b1;
      exp_q.push_back(vals[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if (acc.regA !== e || $isunknown(acc.regA)) begin
        bad++; $display("FAIL boundary%0d regA got=%h want=%h", i, acc.regA, e);
      end
    end
    @(negedge clk);
    acc.load = 1'b0;
    model = 8'h80;
  endtask
  task automatic test_reset_priority;
    @(negedge clk);
    rst = 1'b1;
    acc.load = 1'b1;
    acc.bus = 8'hAA;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (acc.regA !== 8'h00) begin bad++; $display("FAIL rst_priority%0d regA got=%h want=00", i, acc.regA); end
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(8'hAA);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    if (acc.regA !== e) begin bad++; $display("FAIL rst_release regA got=%h want=%h", acc.regA, e); end
    acc.load = 1'b0;
    model = 8'hAA;
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc.bus = 8'($urandom);
      acc.load = 1'($urandom);
      acc.enable_output = 1'($urandom);
      #1;
      total++;
      if (acc.bus_out !== (acc.enable_output ? model : 8'h00)) begin
        bad++; $display("FAIL rand_out%0d bus_out got=%h want=%h", i, acc.bus_out, acc.enable_output ? model : 8'h00);
      end
      if (acc.load) model = acc.bus;
      exp_q.push_back(model);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if (acc.regA !== e) begin bad++; $display("FAIL rand_reg%0d regA got=%h want=%h", i, acc.regA, e); end
    end
    acc.load = 1'b0;
    acc.enable_output = 1'b0;
  endtask
  initial begin
    test_reset;
    test_load;
    test_output_enable;
    test_simultaneous;
    test_boundaries;
    test_reset_priority;
    test_back_to_back;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_empty left=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
